// File: rtl/button_press_classifier.sv
// button_press_classifier: turns a debounced button level into
// one-cycle short/long/double press events plus held/busy levels.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   in           debounced button level, synchronous to clk
//   short_press  pulse: single press released, gap window expired
//   long_press   pulse: press reached LONG_CYCLES high samples
//   double_press pulse: second press started inside the gap window
//   held         level: long press still being held
//   busy         level: classifier not idle
module button_press_classifier #(
    parameter int LONG_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 12_500_000,
    parameter int CNT_W       = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic held,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        LONG_HOLD,
        GAP,
        PRESS2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic short_d, long_d, double_d, held_d, busy_d;
    logic short_q, long_q, double_q, held_q, busy_q;

    // State register; all outputs are registered here too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            held_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            held_q   <= held_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic. cnt holds the number of samples already seen
    // in the current run, so the limit test uses LIMIT-1 and the
    // counter stops before it could ever pass the limit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in) begin
                    state_d = PRESS1;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS1: begin
                if (!in) begin
                    state_d = GAP;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LONG_HOLD: begin
                if (!in) state_d = IDLE;
            end
            GAP: begin
                if (in) begin
                    state_d = PRESS2;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESS2: begin
                if (!in) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: each pulse is tied to one specific transition,
    // which keeps the three pulses mutually exclusive by construction.
    always_comb begin
        long_d   = (state_q == PRESS1) && (state_d == LONG_HOLD);
        double_d = (state_q == GAP) && (state_d == PRESS2);
        short_d  = (state_q == GAP) && (state_d == IDLE);
        held_d   = (state_d == LONG_HOLD);
        busy_d   = (state_d != IDLE);
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = double_q;
    assign held         = held_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with a run-length
// reference model and literal timing checks per scenario.
module tb_button_press_classifier;

    localparam int LONG = 8;
    localparam int GAP  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic d_short, d_long, d_dbl, d_held, d_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // per-scenario observations of the DUT
    int n_short, n_long, n_dbl, n_held;
    int c_short, c_long, c_dbl, c_busy_fall, c_busy_rise;
    logic prev_busy;

    button_press_classifier #(
        .LONG_CYCLES(LONG),
        .GAP_CYCLES (GAP),
        .CNT_W      (4)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .in          (din),
        .short_press (d_short),
        .long_press  (d_long),
        .double_press(d_dbl),
        .held        (d_held),
        .busy        (d_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    // Reference model: described by run lengths of the input since
    // the session began (first high seen while inactive).
    bit active, longd, second;
    int h1, lows;
    bit e_short, e_long, e_dbl;

    task automatic model_step(input bit s);
        e_short = 0;
        e_long  = 0;
        e_dbl   = 0;
        if (!active) begin
            if (s) begin
                active = 1; h1 = 1; lows = 0;
                second = 0; longd = 0;
            end
        end else if (longd || second) begin
            if (!s) active = 0;
        end else if (lows == 0) begin
            if (s) begin
                h1++;
                if (h1 == LONG) begin
                    longd  = 1;
                    e_long = 1;
                end
            end else begin
                lows = 1;
            end
        end else begin
            if (s) begin
                second = 1;
                e_dbl  = 1;
            end else begin
                lows++;
                if (lows == GAP) begin
                    e_short = 1;
                    active  = 0;
                end
            end
        end
    endtask

    // Compare process: model advances on each edge, DUT checked #1 later.
    always @(posedge clk) begin
        if (rst) begin
            active = 0; e_short = 0; e_long = 0; e_dbl = 0;
        end else begin
            model_step(din);
        end
        cyc++;
        #1;
        check("short_press", d_short, e_short);
        check("long_press", d_long, e_long);
        check("double_press", d_dbl, e_dbl);
        check("held", d_held, active && longd);
        check("busy", d_busy, active);
        if (d_short) begin n_short++; c_short = cyc; end
        if (d_long)  begin n_long++;  c_long  = cyc; end
        if (d_dbl)   begin n_dbl++;   c_dbl   = cyc; end
        if (d_held)  n_held++;
        if (prev_busy && !d_busy) c_busy_fall = cyc;
        if (!prev_busy && d_busy) c_busy_rise = cyc;
        prev_busy = d_busy;
    end

    int c0;

    // Called at a negedge; the next edge is offset 1 from c0.
    task automatic start_scn();
        n_short = 0; n_long = 0; n_dbl = 0; n_held = 0;
        c_short = -1; c_long = -1; c_dbl = -1;
        c_busy_fall = -1; c_busy_rise = -1;
        c0 = cyc;
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            din = v;
            @(negedge clk);
        end
    endtask

    initial begin
        prev_busy = 0;
        #1;
        check("reset_short", d_short, 0);
        check("reset_long", d_long, 0);
        check("reset_double", d_dbl, 0);
        check("reset_held", d_held, 0);
        check("reset_busy", d_busy, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        drive(0, 2);

        // short press: high 3, then low
        start_scn();
        drive(1, 3); drive(0, 10);
        check("sp_count", n_short, 1);
        check("sp_at", c_short - c0, 8);
        check("sp_busy_fall", c_busy_fall - c0, 8);
        check("sp_no_long", n_long + n_dbl, 0);

        // long press: high 20, then low
        start_scn();
        drive(1, 20); drive(0, 8);
        check("lp_count", n_long, 1);
        check("lp_at", c_long - c0, 8);
        check("lp_held_cycles", n_held, 13);
        check("lp_held_end", c_busy_fall - c0, 21);
        check("lp_no_short", n_short + n_dbl, 0);

        // double press: high 3, low 2, high 4, low
        start_scn();
        drive(1, 3); drive(0, 2); drive(1, 4); drive(0, 8);
        check("dp_count", n_dbl, 1);
        check("dp_at", c_dbl - c0, 6);
        check("dp_busy_fall", c_busy_fall - c0, 10);
        check("dp_no_short", n_short + n_long, 0);

        // exactly LONG-1 highs is short
        start_scn();
        drive(1, 7); drive(0, 8);
        check("b7_short", n_short, 1);
        check("b7_at", c_short - c0, 12);
        check("b7_long", n_long, 0);

        // exactly LONG highs is long
        start_scn();
        drive(1, 8); drive(0, 4);
        check("b8_long", n_long, 1);
        check("b8_at", c_long - c0, 8);
        check("b8_short", n_short, 0);

        // GAP-1 lows then press is double
        start_scn();
        drive(1, 3); drive(0, 4); drive(1, 2); drive(0, 8);
        check("g4_dbl", n_dbl, 1);
        check("g4_at", c_dbl - c0, 8);
        check("g4_short", n_short, 0);

        // GAP lows is short; next press is a fresh first press
        start_scn();
        drive(1, 3); drive(0, 5); drive(1, 8); drive(0, 3);
        check("g5_short", n_short, 1);
        check("g5_at", c_short - c0, 8);
        check("g5_busy_rise", c_busy_rise - c0, 9);
        check("g5_long_at", c_long - c0, 16);
        check("g5_dbl", n_dbl, 0);

        // reset mid-gap (cnt=3), then release reset with in high
        start_scn();
        drive(1, 3); drive(0, 3);
        rst = 1;
        #1;
        check("rst_busy_now", d_busy, 0);
        check("rst_pulses_now", d_short | d_long | d_dbl | d_held, 0);
        @(negedge clk);
        drive(0, 2);
        start_scn();
        rst = 0;
        drive(1, 10); drive(0, 8);
        check("rst_busy_rise", c_busy_rise - c0, 1);
        check("rst_long_at", c_long - c0, 8);
        check("rst_no_short", n_short + n_dbl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_press_classifier.md
# button_press_classifier

Downstream consumer of the debounced button level produced by `debounce_fsm`. Turns the clean level into single-cycle gesture events: short press, long press and double press. It also gives a `held` level while a long press continues. It runs entirely in the `clk` domain and feeds the control/UI logic directly.

## Interface
- `LONG_CYCLES`, default 25_000_000: consecutive high samples that make a long press (0.5 s at 50 MHz). Must be ≥ 2.
- `GAP_CYCLES`, default 12_500_000: consecutive low samples after a short press that close the double-press window. Must be ≥ 2.
- `CNT_W`, default 25: counter width. Must satisfy 2^CNT_W > max(LONG_CYCLES, GAP_CYCLES).
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in` input 1: debounced button level, synchronous to `clk`.
- `short_press` output 1: one-cycle pulse for a single short press.
- `long_press` output 1: one-cycle pulse when a press reaches LONG_CYCLES.
- `double_press` output 1: one-cycle pulse at the start of a second press that falls inside the gap window.
- `held` output 1: level, high while a long press continues.
- `busy` output 1: level, high whenever the state is not IDLE.

## Operation
- Internal state: `state` (IDLE, PRESS1, LONG_HOLD, GAP, PRESS2) and `cnt` (CNT_W bits). All outputs are registered.
- Reset (async, active-high): state=IDLE, cnt=0, all outputs 0.
- Default: the three pulse outputs return to 0 every cycle unless set below.
- IDLE:
  - in=1: go to PRESS1, cnt←1. This edge is high sample 1.
  - Otherwise stay.
- PRESS1:
  - in=0: go to GAP, cnt←1. This edge is low sample 1.
  - in=1 and cnt==LONG_CYCLES-1: long_press←1, go to LONG_HOLD.
  - Else cnt←cnt+1.
- LONG_HOLD:
  - in=0: go to IDLE.
  - A release never produces short_press or double_press.
- GAP (in=1 has priority):
  - in=1: double_press←1, go to PRESS2.
  - in=0 and cnt==GAP_CYCLES-1: short_press←1, go to IDLE.
  - Else cnt←cnt+1.
- PRESS2:
  - in=0: go to IDLE.
  - The second press length is not classified; no long_press is generated from PRESS2.
- held = (state==LONG_HOLD). busy = (state!=IDLE). Both are registered alongside `state`.
- At most one pulse per cycle; the three pulse outputs are mutually exclusive.
- `cnt` never wraps. Every path that could exceed its limit leaves the state at that limit.

## Timing
- long_press is high in the cycle after the LONG_CYCLES-th consecutive high sample. held rises in the same cycle.
- A press of exactly LONG_CYCLES-1 high samples is a short press.
- short_press is high in the cycle after the GAP_CYCLES-th consecutive low sample following release. This gives a latency of GAP_CYCLES cycles from the release sample.
- double_press is high in the cycle after the first high sample in GAP.
  - Up to GAP_CYCLES-1 low samples before the re-press still yields double_press.
  - Exactly GAP_CYCLES low samples yields short_press; a press on the next edge starts a fresh PRESS1 from IDLE.
- held and busy fall in the cycle after the release sample in LONG_HOLD or PRESS2.
- Reset mid-operation: outputs go to 0 immediately and any pending event is discarded.
- If in=1 when reset deasserts, the first edge counts as high sample 1 of a new press.

## Test plan
Bench parameters: LONG_CYCLES=8, GAP_CYCLES=5.
- Short press: in high 3 cycles, then low.
  - Required: short_press high for exactly 1 cycle, 5 cycles after the first low sample.
  - long_press and double_press stay 0.
  - busy falls together with the short_press pulse.
- Long press: in high 20 cycles, then low.
  - Required: long_press 1 cycle after the 8th high sample.
  - held high from that cycle until 1 cycle after release.
  - No short_press afterwards.
- Double press: high 3, low 2, high 4, low.
  - Required: double_press 1 cycle after the first high sample of the second press.
  - No short_press.
  - busy returns to 0 one cycle after the final release.
- Length boundaries:
  - High exactly 7 → short_press.
  - High exactly 8 → long_press.
  - Gap of 4 lows then high → double_press.
  - Gap of 5 lows → short_press, and a following press enters PRESS1.
- Reset mid-gap: assert reset while in GAP with cnt=3.
  - Required: all outputs 0 at once and no pulse.
  - Deassert reset with in=1: busy=1 next cycle, and long_press after 8 high samples.
